xyolo_read_sched: RTL
=====================

// Module: xyolo_read_sched
// PURPOSE
//  Tile sequencer for the xyolo_read weight/bias loader. Programs its config registers over the
//  valid/addr/wdata/wstrb port, pulses run and waits for done, once per tile. Issues n_tiles+1 runs:
//  run 0 loads only, middle runs load tile r while reading tile r-1, last run reads only.
//  Sits between the CPU layer-descriptor registers and xyolo_read.
// PARAMETERS
//  IO_ADDR_W   32  external address width
//  MEM_ADDR_W  10  internal memory address width
//  PERIOD_W    10  addrgen period width
//  CFG_ADDR_W   4  xyolo_read config address width
//  TILES_W     16  tile counter width
//  MUL_LAT      4  cycles from last EXT_ADDR/OFFSET write until the per-vector addresses are valid
//  GUARD        2  cycles after run during which read_done is ignored
// PORTS
//  clk          in   1           clock
//  rst          in   1           async reset, ACTIVE-LOW
//  start        in   1           latch descriptor, begin sequence (IDLE only)
//  abort        in   1           stop sequence
//  base_addr    in   IO_ADDR_W   ext address of tile 0
//  tile_stride  in   IO_ADDR_W   ext address increment per tile
//  offset       in   IO_ADDR_W/2 per-vector ext address offset
//  int_addr     in   MEM_ADDR_W  internal start address
//  n_tiles      in   TILES_W     number of tiles
//  iterA/perA/shiftA/incrA                in  load-pattern config (MEM_ADDR_W/PERIOD_W)
//  iterB/perB/startB/shiftB/incrB         in  read-pattern config (MEM_ADDR_W/PERIOD_W)
//  step_ok      in   1           consumer ready for next run
//  busy         out  1           sequence in progress
//  sched_done   out  1           1-cycle pulse at end of sequence or abort
//  tile_idx     out  TILES_W     current run index r
//  cfg_valid    out  1           config write strobe to xyolo_read
//  cfg_addr     out  CFG_ADDR_W  config register index
//  cfg_wdata    out  IO_ADDR_W   config data, zero-extended
//  cfg_wstrb    out  1           = cfg_valid
//  read_clear   out  1           clear pulse to xyolo_read
//  read_run     out  1           run pulse to xyolo_read
//  read_done    in   1           done from xyolo_read
// BEHAVIOUR
//  Reset (rst=0): state IDLE; all outputs 0; counters and latched descriptor 0.
//  Config map: EXT_ADDR=0 OFFSET=1 INT_ADDR=2 ITER_A=3 PER_A=4 SHIFT_A=5 INCR_A=6 ITER_B=7
//    PER_B=8 START_B=9 SHIFT_B=10 INCR_B=11.
//  FSM: IDLE->CLR->CFG->SETTLE->GATE->RUN->GUARD->WAIT->(CFG | FIN)->IDLE.
//   IDLE: start=1 latches all descriptor inputs, sets r=0 and ea=base_addr, goes to CLR.
//     start is ignored in any other state.
//   CLR: read_clear=1 for 1 cycle. If n_tiles==0, go to FIN.
//   CFG: one write per cycle, cfg_valid=1.
//     r==0: all 12 registers in index order.
//     r>0:  EXT_ADDR, ITER_A, ITER_B only.
//     EXT_ADDR data = ea; ITER_A data = (r<n_tiles)?iterA:0; ITER_B data = (r>0)?iterB:0.
//   SETTLE: MUL_LAT idle cycles after the final CFG write.
//   GATE: hold until step_ok=1.
//   RUN: read_run=1 for exactly 1 cycle.
//   GUARD: GUARD cycles; read_done ignored.
//   WAIT: hold until read_done=1. Then r<=r+1 and ea<=ea+tile_stride (mod 2^IO_ADDR_W).
//     Next is FIN if the new r>n_tiles, else CFG.
//   FIN: sched_done=1 for 1 cycle, then IDLE.
//  busy=1 in every state except IDLE. tile_idx=r.
//  Abort:
//   In CLR/CFG/SETTLE/GATE: go straight to FIN. No read_run is issued.
//   In RUN/GUARD/WAIT: finish the current WAIT, then FIN (the run already issued is not killed).
//   abort together with start in IDLE: start wins; abort is sampled from the next cycle.
//  r counts to n_tiles inclusive; TILES_W must hold n_tiles+1. No wrap is checked.
//  Async reset mid-sequence: immediate IDLE, outputs 0. The xyolo_read engine is not drained.
// TESTING
//  T1 reset: rst=0 mid-WAIT -> next edge all outputs 0, busy=0; after release, start runs normally.
//  T2 n_tiles=2, base=0x1000, stride=0x200, iterA=8, iterB=8, step_ok=1:
//     3 read_run pulses; EXT_ADDR=0x1000/0x1200/0x1400; ITER_A=8/8/0; ITER_B=0/8/8;
//     12+3+3 cfg writes; one sched_done.
//  T3 timing: read_run never <MUL_LAT+1 cycles after last cfg write;
//     read_done=1 held high through GUARD -> not taken as completion.
//  T4 step_ok=0 for 10 cycles in GATE -> read_run delayed exactly until step_ok rises; busy stays 1.
//  T5 abort in CFG of run 1 -> no further read_run, sched_done 1 cycle later.
//     abort in WAIT -> exits only after read_done.
//  T6 n_tiles=0 -> read_clear, then sched_done; no cfg writes, no read_run.
//     stride=0xFFFFFF00, base=0x200 -> EXT_ADDR=0x200, 0x100, 0x0 (wraps).

Source files
------------

// File: rtl/xyolo_read_sched.sv
// Tile sequencer for xyolo_read: programs its config registers, then pulses run and waits
// for done once per tile, overlapping the load of tile r with the read of tile r-1.
module xyolo_read_sched #(
    parameter int IO_ADDR_W  = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int PERIOD_W   = 10,
    parameter int CFG_ADDR_W = 4,
    parameter int TILES_W    = 16,
    parameter int MUL_LAT    = 4,
    parameter int GUARD      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [IO_ADDR_W-1:0]    base_addr,
    input  logic [IO_ADDR_W-1:0]    tile_stride,
    input  logic [IO_ADDR_W/2-1:0]  offset,
    input  logic [MEM_ADDR_W-1:0]   int_addr,
    input  logic [TILES_W-1:0]      n_tiles,
    input  logic [MEM_ADDR_W-1:0]   iterA,
    input  logic [PERIOD_W-1:0]     perA,
    input  logic [MEM_ADDR_W-1:0]   shiftA,
    input  logic [MEM_ADDR_W-1:0]   incrA,
    input  logic [MEM_ADDR_W-1:0]   iterB,
    input  logic [PERIOD_W-1:0]     perB,
    input  logic [MEM_ADDR_W-1:0]   startB,
    input  logic [MEM_ADDR_W-1:0]   shiftB,
    input  logic [MEM_ADDR_W-1:0]   incrB,
    input  logic                    step_ok,
    output logic                    busy,
    output logic                    sched_done,
    output logic [TILES_W-1:0]      tile_idx,
    output logic                    cfg_valid,
    output logic [CFG_ADDR_W-1:0]   cfg_addr,
    output logic [IO_ADDR_W-1:0]    cfg_wdata,
    output logic                    cfg_wstrb,
    output logic                    read_clear,
    output logic                    read_run,
    input  logic                    read_done
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CLR    = 4'd1;
    localparam logic [3:0] S_CFG    = 4'd2;
    localparam logic [3:0] S_SETTLE = 4'd3;
    localparam logic [3:0] S_GATE   = 4'd4;
    localparam logic [3:0] S_RUN    = 4'd5;
    localparam logic [3:0] S_GUARD  = 4'd6;
    localparam logic [3:0] S_WAIT   = 4'd7;
    localparam logic [3:0] S_FIN    = 4'd8;

    localparam logic [CFG_ADDR_W-1:0] REG_EXT_ADDR = CFG_ADDR_W'(0);
    localparam logic [CFG_ADDR_W-1:0] REG_OFFSET   = CFG_ADDR_W'(1);
    localparam logic [CFG_ADDR_W-1:0] REG_INT_ADDR = CFG_ADDR_W'(2);
    localparam logic [CFG_ADDR_W-1:0] REG_ITER_A   = CFG_ADDR_W'(3);
    localparam logic [CFG_ADDR_W-1:0] REG_PER_A    = CFG_ADDR_W'(4);
    localparam logic [CFG_ADDR_W-1:0] REG_SHIFT_A  = CFG_ADDR_W'(5);
    localparam logic [CFG_ADDR_W-1:0] REG_INCR_A   = CFG_ADDR_W'(6);
    localparam logic [CFG_ADDR_W-1:0] REG_ITER_B   = CFG_ADDR_W'(7);
    localparam logic [CFG_ADDR_W-1:0] REG_PER_B    = CFG_ADDR_W'(8);
    localparam logic [CFG_ADDR_W-1:0] REG_START_B  = CFG_ADDR_W'(9);
    localparam logic [CFG_ADDR_W-1:0] REG_SHIFT_B  = CFG_ADDR_W'(10);
    localparam logic [CFG_ADDR_W-1:0] REG_INCR_B   = CFG_ADDR_W'(11);

    localparam int TMR_W = 8;

    logic [3:0]              state;
    logic [TILES_W-1:0]      r;
    logic [IO_ADDR_W-1:0]    ea;
    logic [CFG_ADDR_W-1:0]   cfg_sel;
    logic [TMR_W-1:0]        tmr;
    logic                    abort_pend;

    logic [IO_ADDR_W-1:0]    lat_stride;
    logic [IO_ADDR_W/2-1:0]  lat_offset;
    logic [MEM_ADDR_W-1:0]   lat_int_addr;
    logic [TILES_W-1:0]      lat_n_tiles;
    logic [MEM_ADDR_W-1:0]   lat_iter_a, lat_shift_a, lat_incr_a;
    logic [PERIOD_W-1:0]     lat_per_a, lat_per_b;
    logic [MEM_ADDR_W-1:0]   lat_iter_b, lat_start_b, lat_shift_b, lat_incr_b;

    logic                    cfg_last;
    logic [CFG_ADDR_W-1:0]   cfg_next;

    // Run 0 writes the full map; later runs only rewrite EXT_ADDR, ITER_A, ITER_B.
    always_comb begin
        cfg_last = 1'b0;
        cfg_next = cfg_sel;
        if (r == '0) begin
            cfg_last = (cfg_sel == REG_INCR_B);
            cfg_next = cfg_sel + CFG_ADDR_W'(1);
        end else begin
            cfg_last = (cfg_sel == REG_ITER_B);
            cfg_next = (cfg_sel == REG_EXT_ADDR) ? REG_ITER_A : REG_ITER_B;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            r            <= '0;
            ea           <= '0;
            cfg_sel      <= '0;
            tmr          <= '0;
            abort_pend   <= 1'b0;
            lat_stride   <= '0;
            lat_offset   <= '0;
            lat_int_addr <= '0;
            lat_n_tiles  <= '0;
            lat_iter_a   <= '0;
            lat_per_a    <= '0;
            lat_shift_a  <= '0;
            lat_incr_a   <= '0;
            lat_iter_b   <= '0;
            lat_per_b    <= '0;
            lat_start_b  <= '0;
            lat_shift_b  <= '0;
            lat_incr_b   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    lat_stride   <= tile_stride;
                    lat_offset   <= offset;
                    lat_int_addr <= int_addr;
                    lat_n_tiles  <= n_tiles;
                    lat_iter_a   <= iterA;
                    lat_per_a    <= perA;
                    lat_shift_a  <= shiftA;
                    lat_incr_a   <= incrA;
                    lat_iter_b   <= iterB;
                    lat_per_b    <= perB;
                    lat_start_b  <= startB;
                    lat_shift_b  <= shiftB;
                    lat_incr_b   <= incrB;
                    r            <= '0;
                    ea           <= base_addr;
                    abort_pend   <= 1'b0;
                    state        <= S_CLR;
                end
                S_CLR: begin
                    cfg_sel <= '0;
                    state   <= (abort || lat_n_tiles == '0) ? S_FIN : S_CFG;
                end
                S_CFG: begin
                    if (abort) begin
                        state <= S_FIN;
                    end else if (cfg_last) begin
                        tmr   <= TMR_W'(MUL_LAT - 1);
                        state <= S_SETTLE;
                    end else begin
                        cfg_sel <= cfg_next;
                    end
                end
                S_SETTLE: begin
                    if (abort)            state <= S_FIN;
                    else if (tmr == '0)   state <= S_GATE;
                    else                  tmr   <= tmr - TMR_W'(1);
                end
                S_GATE: begin
                    if (abort)        state <= S_FIN;
                    else if (step_ok) state <= S_RUN;
                end
                S_RUN: begin
                    abort_pend <= abort_pend | abort;
                    tmr        <= TMR_W'(GUARD - 1);
                    state      <= S_GUARD;
                end
                S_GUARD: begin
                    abort_pend <= abort_pend | abort;
                    if (tmr == '0) state <= S_WAIT;
                    else           tmr   <= tmr - TMR_W'(1);
                end
                S_WAIT: begin
                    abort_pend <= abort_pend | abort;
                    if (read_done) begin
                        r       <= r + TILES_W'(1);
                        ea      <= ea + lat_stride;
                        cfg_sel <= '0;
                        // r >= n_tiles here means the incremented r exceeds n_tiles.
                        state   <= (abort_pend || abort || r >= lat_n_tiles) ? S_FIN : S_CFG;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_wdata = '0;
        if (state == S_CFG) begin
            case (cfg_sel)
                REG_EXT_ADDR: cfg_wdata = ea;
                REG_OFFSET:   cfg_wdata = IO_ADDR_W'(lat_offset);
                REG_INT_ADDR: cfg_wdata = IO_ADDR_W'(lat_int_addr);
                REG_ITER_A:   cfg_wdata = (r < lat_n_tiles) ? IO_ADDR_W'(lat_iter_a) : '0;
                REG_PER_A:    cfg_wdata = IO_ADDR_W'(lat_per_a);
                REG_SHIFT_A:  cfg_wdata = IO_ADDR_W'(lat_shift_a);
                REG_INCR_A:   cfg_wdata = IO_ADDR_W'(lat_incr_a);
                REG_ITER_B:   cfg_wdata = (r != '0) ? IO_ADDR_W'(lat_iter_b) : '0;
                REG_PER_B:    cfg_wdata = IO_ADDR_W'(lat_per_b);
                REG_START_B:  cfg_wdata = IO_ADDR_W'(lat_start_b);
                REG_SHIFT_B:  cfg_wdata = IO_ADDR_W'(lat_shift_b);
                REG_INCR_B:   cfg_wdata = IO_ADDR_W'(lat_incr_b);
                default:      cfg_wdata = '0;
            endcase
        end
    end

    assign busy       = (state != S_IDLE);
    assign sched_done = (state == S_FIN);
    assign tile_idx   = r;
    assign cfg_valid  = (state == S_CFG);
    assign cfg_addr   = cfg_valid ? cfg_sel : '0;
    assign cfg_wstrb  = cfg_valid;
    assign read_clear = (state == S_CLR);
    assign read_run   = (state == S_RUN);

endmodule
